// File: rtl/unet_wrapper_pkg.sv
// Shared types and constants for the done-flag writer and its polling reader.
// READBACK_CHECK_EN adds the readback states to the state enum.
package unet_wrapper_pkg;

  localparam logic [31:0] WORD_BYTES        = 32'd4;
  localparam logic [31:0] DEFAULT_DONE_WORD = 32'h0005_0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PAYLOAD,
    S_FLAG,
`ifdef READBACK_CHECK_EN
    S_RB_ADDR,
    S_RB_WAIT,
`endif
    S_FIN
  } state_e;

  // Byte address of word slot idx relative to base (no wrap checking).
  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [3:0]  idx
  );
    return base + ({28'd0, idx} * WORD_BYTES);
  endfunction

endpackage

// File: rtl/done_flag_wr.sv
// done_flag_wr: clears the flag word, writes payload words, then the flag.
// Define READBACK_CHECK_EN to re-read the flag and raise a sticky err.
module done_flag_wr
  import unet_wrapper_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter logic [31:0] DONE_WORD  = DEFAULT_DONE_WORD,
  parameter int unsigned NUM_WORDS  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        ram_clk,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wd_data,
  input  logic [31:0] ram_rd_data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  state_e      r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_addr;
  logic        r_en;
  logic [3:0]  r_we;
  logic [31:0] r_wd;
  logic        r_done;

  // Sequencer: every bus action is registered as its state is left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_addr  <= 32'd0;
      r_en    <= 1'b0;
      r_we    <= 4'h0;
      r_wd    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_we   <= 4'h0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= 4'd0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_addr  <= START_ADDR;
          r_wd    <= 32'd0;
          r_en    <= 1'b1;
          r_we    <= 4'hF;
          r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (pl_valid) begin
            r_addr <= word_addr(START_ADDR, r_idx + 4'd1);
            r_wd   <= pl_data;
            r_en   <= 1'b1;
            r_we   <= 4'hF;
            r_idx  <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) begin
              r_state <= S_FLAG;
            end
          end
        end
        S_FLAG: begin
          r_addr  <= START_ADDR;
          r_wd    <= DONE_WORD;
          r_en    <= 1'b1;
          r_we    <= 4'hF;
`ifdef READBACK_CHECK_EN
          r_state <= S_RB_ADDR;
`else
          r_state <= S_FIN;
`endif
        end
`ifdef READBACK_CHECK_EN
        S_RB_ADDR: begin
          r_addr  <= START_ADDR;
          r_en    <= 1'b1;
          r_state <= S_RB_WAIT;
        end
        S_RB_WAIT: begin
          r_state <= S_FIN;
        end
`endif
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef READBACK_CHECK_EN
  logic r_err;

  // Sticky readback error; the read data lands one cycle after RB_WAIT,
  // so the check is taken on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_err <= 1'b0;
    end else if (r_state == S_FIN && ram_rd_data != DONE_WORD) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^ram_rd_data;
  assign err = 1'b0;
`endif

  assign busy        = (r_state != S_IDLE);
  assign pl_ready    = (r_state == S_PAYLOAD);
  assign done        = r_done;
  assign ram_clk     = clk;
  assign ram_rst     = 1'b0;
  assign ram_addr    = r_addr;
  assign ram_en      = r_en;
  assign ram_we      = r_we;
  assign ram_wd_data = r_wd;

endmodule

// File: doc/done_flag_wr.md
DONE_FLAG_WR -- requirements
Module: done_flag_wr

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h4580_0000; BRAM byte address of the done-flag word.
REQ-002 SHALL have parameter DONE_WORD, default 32'h0005_0010; value that signals transfer complete to the polling reader.
REQ-003 SHALL have parameter NUM_WORDS, default 2, legal range 1..15; payload words written after the flag word.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: start  in  1  begin one publish sequence; busy  out  1  sequence in progress.
REQ-006 SHALL have ports: done  out  1  one-cycle completion pulse; err  out  1  readback mismatch flag.
REQ-007 SHALL have ports: pl_data  in  32  payload word; pl_valid  in  1  payload offered; pl_ready  out  1  payload accepted.
REQ-008 SHALL have ports: ram_clk  out  1  =clk; ram_rst  out  1  constant 0; ram_addr  out  32  byte address; ram_en  out  1  port enable; ram_we  out  4  byte write enables.
REQ-009 SHALL have ports: ram_wd_data  out  32  write data; ram_rd_data  in  32  read data, one-cycle BRAM latency.

Function
REQ-010 SHALL implement states IDLE, CLEAR, PAYLOAD, FLAG, RB_ADDR, RB_WAIT, FIN.
REQ-011 SHALL register ram_addr, ram_en, ram_we and ram_wd_data. Each write is a single cycle with ram_en=1 and ram_we=4'hF. In all other cycles ram_en=0 and ram_we=0.
REQ-012 In IDLE, start=1 SHALL move to CLEAR.
REQ-013 CLEAR SHALL write 32'h0 to START_ADDR so the reader cannot see a stale flag, then move to PAYLOAD.
REQ-014 In PAYLOAD, pl_ready SHALL be 1. Payload word i (0-based) SHALL be written to START_ADDR+4*(i+1) in the cycle after pl_valid&&pl_ready.
REQ-015 While pl_valid=0, PAYLOAD SHALL stall with no bus activity.
REQ-016 PAYLOAD SHALL move to FLAG after NUM_WORDS words are accepted. pl_ready SHALL be 0 in every state other than PAYLOAD.
REQ-017 FLAG SHALL write DONE_WORD to START_ADDR, strictly after every payload write.
REQ-018 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 start asserted in the FIN cycle SHALL be ignored; a new sequence needs start in IDLE.
REQ-022 The payload index counter SHALL be 4 bits wide and SHALL clear on entry to CLEAR.
REQ-023 Address arithmetic SHALL be 32-bit unsigned with no wrap checking.
REQ-024 Bus timing with pl_valid held 1, NUM_WORDS=2 and start sampled at edge k: clear write in cycle k+1, payload writes in k+2 and k+3, flag write in k+4.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, regardless of the current state.
REQ-026 Reset SHALL set outputs to: busy=0, done=0, err=0, pl_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wd_data=0.
REQ-027 Reset mid-sequence SHALL abort the sequence. No further writes SHALL occur, and the flag SHALL NOT be written.

Configuration
REQ-028 The macro READBACK_CHECK_EN SHALL control flag readback.
REQ-029 With READBACK_CHECK_EN defined, FLAG SHALL go to RB_ADDR.
REQ-030 RB_ADDR SHALL drive ram_en=1, ram_we=0, ram_addr=START_ADDR.
REQ-031 RB_WAIT SHALL compare ram_rd_data with DONE_WORD one cycle after the RB_ADDR read. On mismatch, err SHALL set; it is sticky until the next accepted start. RB_WAIT SHALL then go to FIN.
REQ-032 With READBACK_CHECK_EN defined, done SHALL occur in cycle k+7 under REQ-024 conditions.
REQ-033 Without READBACK_CHECK_EN, FLAG SHALL go directly to FIN. done SHALL occur in cycle k+5, err SHALL be tied 0, and RB_ADDR/RB_WAIT SHALL not exist.

Structure
REQ-034 unet_wrapper_pkg SHALL hold the state enum typedef, WORD_BYTES=4 and DEFAULT_DONE_WORD=32'h0005_0010. The reader block and this block SHALL share DEFAULT_DONE_WORD.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 Test: NUM_WORDS=2, pl_valid=1, pl_data=A1,A2, pulse start. Expect writes (4580_0000,0), (4580_0004,A1), (4580_0008,A2), (4580_0000,0005_0010) in k+1..k+4; done at k+5 (k+7 with READBACK_CHECK_EN).
REQ-037 Test: drop pl_valid for 3 cycles after the first payload word. Expect pl_ready=1 throughout, no bus writes during the gap, and the flag written only after A2.
REQ-038 Test: pulse start at k+2 during a sequence. Expect no restart and exactly one done.
REQ-039 Test: with READBACK_CHECK_EN defined, BRAM model returns 0000_0000 on readback. Expect err=1 at done; err=0 after the next start.
REQ-040 Test: assert rst_n=0 at k+3. Expect outputs at reset values at the next edge, no flag write, and IDLE.
REQ-041 Test: NUM_WORDS=1, pulse start twice back-to-back. Expect the second start accepted only in IDLE and two identical 3-write sequences.
